ps2_rx: RTL and testbench

- Host-side PS/2 receiver that decodes keyboard frames arriving on PS2_CLK/PS2_DATA into scancode bytes and key events.
- Sits in Top beside HexDisplay. Its key events feed ledData/CPU input the same way HexDisplay consumes output data.
- Receive only: the block never drives PS2_CLK or PS2_DATA.

---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_if.sv | 29 ++
 rtl/ps2_filter.sv | 52 +++++
 rtl/ps2_rx.sv | 191 +++++++++++++++++++
 tb/tb_ps2_rx.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_PARITY  = 2'd1;
  localparam logic [1:0] ERR_FRAME   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  // Odd parity holds when the eight data bits plus the parity bit XOR to 1.
  function automatic logic parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_if.sv
// PS/2 pins plus the decoded byte/key-event outputs of the receiver.
interface ps2_if;

  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] raw_code;
  logic       raw_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic       key_valid;
  logic       err;
  logic [1:0] err_code;
  logic       busy;

  // master drives the pins and consumes events; slave is the receiver.
  modport master (
    output ps2_clk, ps2_data,
    input  raw_code, raw_valid, key_code, key_ext, key_break, key_valid,
    input  err, err_code, busy
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output raw_code, raw_valid, key_code, key_ext, key_break, key_valid,
    output err, err_code, busy
  );

endinterface

// File: rtl/ps2_filter.sv
// Two-flop synchronizer followed by a stability filter for one PS/2 pin.
module ps2_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic filt
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             filt_q,  filt_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  // The counter tracks how long the synchronized value has disagreed with
  // the filtered one; any return to agreement restarts it.
  always_comb begin
    sync1_d = pin;
    sync2_d = sync1_q;
    filt_d  = filt_q;
    cnt_d   = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Idle PS/2 lines are high, so everything resets to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign filt = filt_q;

endmodule

// File: rtl/ps2_rx.sv
// Host-side PS/2 receiver: decodes keyboard frames into bytes and key events
// (E0 extended / F0 break prefixes folded into the following scancode).
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_US = 2000
) (
  input logic  CLK100MHZ,
  input logic  RESETN,
  ps2_if.slave bus
);

  localparam int TO_CYCLES = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int TO_W      = $clog2(TO_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_RELOAD = TO_W'(TO_CYCLES - 1);

  logic clk_filt;
  logic data_filt;

  ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk   (CLK100MHZ),
    .rst_n (RESETN),
    .pin   (bus.ps2_clk),
    .filt  (clk_filt)
  );

  ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk   (CLK100MHZ),
    .rst_n (RESETN),
    .pin   (bus.ps2_data),
    .filt  (data_filt)
  );

  ps2_state_e      state_q,     state_d;
  logic [2:0]      bit_cnt_q,   bit_cnt_d;
  logic [7:0]      shift_q,     shift_d;
  logic            parity_q,    parity_d;
  logic [TO_W-1:0] to_cnt_q,    to_cnt_d;
  logic            clk_prev_q,  clk_prev_d;
  logic            fall_q,      fall_d;
  logic            ext_pend_q,  ext_pend_d;
  logic            brk_pend_q,  brk_pend_d;
  logic [7:0]      raw_code_q,  raw_code_d;
  logic            raw_valid_q, raw_valid_d;
  logic [7:0]      key_code_q,  key_code_d;
  logic            key_ext_q,   key_ext_d;
  logic            key_break_q, key_break_d;
  logic            key_valid_q, key_valid_d;
  logic            err_q,       err_d;
  logic [1:0]      err_code_q,  err_code_d;
  logic            busy_q,      busy_d;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    to_cnt_d    = to_cnt_q;
    ext_pend_d  = ext_pend_q;
    brk_pend_d  = brk_pend_q;
    raw_code_d  = raw_code_q;
    raw_valid_d = 1'b0;
    key_code_d  = key_code_q;
    key_ext_d   = key_ext_q;
    key_break_d = key_break_q;
    key_valid_d = 1'b0;
    err_d       = 1'b0;
    err_code_d  = err_code_q;

    // The edge pulse is registered once more to line the FSM up with
    // the filtered data sample.
    clk_prev_d = clk_filt;
    fall_d     = clk_prev_q & ~clk_filt;

    if (fall_q) begin
      to_cnt_d = TO_RELOAD;
    end else if (state_q != IDLE && to_cnt_q != '0) begin
      to_cnt_d = to_cnt_q - TO_W'(1);
    end

    if (fall_q) begin
      unique case (state_q)
        IDLE: begin
          if (!data_filt) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end
        end
        DATA: begin
          shift_d   = {data_filt, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          parity_d = data_filt;
          state_d  = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!data_filt || !parity_ok(shift_q, parity_q)) begin
            err_d      = 1'b1;
            err_code_d = !data_filt ? ERR_FRAME : ERR_PARITY;
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
          end else begin
            raw_code_d  = shift_q;
            raw_valid_d = 1'b1;
            if (shift_q == PS2_EXT) begin
              ext_pend_d = 1'b1;
            end else if (shift_q == PS2_BRK) begin
              brk_pend_d = 1'b1;
            end else begin
              key_code_d  = shift_q;
              key_ext_d   = ext_pend_q;
              key_break_d = brk_pend_q;
              key_valid_d = 1'b1;
              ext_pend_d  = 1'b0;
              brk_pend_d  = 1'b0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && to_cnt_q == '0) begin
      state_d    = IDLE;
      err_d      = 1'b1;
      err_code_d = ERR_TIMEOUT;
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK100MHZ or negedge RESETN) begin
    if (!RESETN) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      to_cnt_q    <= '0;
      clk_prev_q  <= 1'b1;
      fall_q      <= 1'b0;
      ext_pend_q  <= 1'b0;
      brk_pend_q  <= 1'b0;
      raw_code_q  <= '0;
      raw_valid_q <= 1'b0;
      key_code_q  <= '0;
      key_ext_q   <= 1'b0;
      key_break_q <= 1'b0;
      key_valid_q <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      to_cnt_q    <= to_cnt_d;
      clk_prev_q  <= clk_prev_d;
      fall_q      <= fall_d;
      ext_pend_q  <= ext_pend_d;
      brk_pend_q  <= brk_pend_d;
      raw_code_q  <= raw_code_d;
      raw_valid_q <= raw_valid_d;
      key_code_q  <= key_code_d;
      key_ext_q   <= key_ext_d;
      key_break_q <= key_break_d;
      key_valid_q <= key_valid_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.raw_code  = raw_code_q;
  assign bus.raw_valid = raw_valid_q;
  assign bus.key_code  = key_code_q;
  assign bus.key_ext   = key_ext_q;
  assign bus.key_break = key_break_q;
  assign bus.key_valid = key_valid_q;
  assign bus.err       = err_q;
  assign bus.err_code  = err_code_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Scoreboard bench for ps2_rx: a keyboard model drives frames, expected
// bytes/key events/errors are queued at drive time and popped on DUT pulses.
module tb_ps2_rx;
  import ps2_pkg::*;

  localparam int CLK_HZ     = 100_000_000;
  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT_US = 20;
  localparam int TO_CYCLES  = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int LATENCY    = FILTER_LEN + 4;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } key_exp_t;

  typedef struct {
    logic [1:0] code;
    int         lo;
    int         hi;
  } err_exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  ps2_if bus();

  ps2_rx #(
    .CLK_HZ     (CLK_HZ),
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_US (TIMEOUT_US)
  ) dut (
    .CLK100MHZ (clk),
    .RESETN    (resetn),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int compCount = 0;
  int failCount = 0;
  int cyc = 0;
  int last_fall_cyc = 0;

  logic [7:0] raw_q[$];
  key_exp_t   key_q[$];
  err_exp_t   err_q[$];
  logic       model_ext = 1'b0;
  logic       model_brk = 1'b0;

  logic [7:0] raw_exp;
  key_exp_t   key_exp;
  err_exp_t   err_exp;
  int         lat;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Pops the matching expectation for every pulse the DUT produces.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      lat = cyc - last_fall_cyc;
      if (bus.err) begin
        checkOutput("err_valid_overlap", 32'(bus.raw_valid | bus.key_valid), 32'd0);
        if (err_q.size() == 0) begin
          checkOutput("err_spurious", 32'(err_q.size()), 32'd1);
        end else begin
          err_exp = err_q.pop_front();
          checkOutput("err_code", 32'(bus.err_code), 32'(err_exp.code));
          checkOutput("err_latency_in_range", 32'(lat >= err_exp.lo && lat <= err_exp.hi), 32'd1);
        end
      end
      if (bus.raw_valid) begin
        if (raw_q.size() == 0) begin
          checkOutput("raw_spurious", 32'(raw_q.size()), 32'd1);
        end else begin
          raw_exp = raw_q.pop_front();
          checkOutput("raw_code", 32'(bus.raw_code), 32'(raw_exp));
          checkOutput("raw_latency", 32'(lat), 32'(LATENCY));
        end
      end
      if (bus.key_valid) begin
        if (key_q.size() == 0) begin
          checkOutput("key_spurious", 32'(key_q.size()), 32'd1);
        end else begin
          key_exp = key_q.pop_front();
          checkOutput("key_code", 32'(bus.key_code), 32'(key_exp.code));
          checkOutput("key_ext", 32'(bus.key_ext), 32'(key_exp.ext));
          checkOutput("key_break", 32'(bus.key_break), 32'(key_exp.brk));
        end
      end
    end
  end

  task automatic sendBit(input logic b);
    bus.ps2_data = b;
    repeat (20) @(negedge clk);
    bus.ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    repeat (40) @(negedge clk);
    bus.ps2_clk = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit bad_parity, input bit bad_stop);
    logic     par;
    err_exp_t e;
    par = ~(^b);
    if (bad_parity) par = ~par;
    if (bad_stop || bad_parity) begin
      e.code = bad_stop ? ERR_FRAME : ERR_PARITY;
      e.lo   = LATENCY;
      e.hi   = LATENCY;
      err_q.push_back(e);
      model_ext = 1'b0;
      model_brk = 1'b0;
    end else begin
      raw_q.push_back(b);
      if (b == 8'hE0) begin
        model_ext = 1'b1;
      end else if (b == 8'hF0) begin
        model_brk = 1'b1;
      end else begin
        key_q.push_back('{code: b, ext: model_ext, brk: model_brk});
        model_ext = 1'b0;
        model_brk = 1'b0;
      end
    end
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(b[i]);
    sendBit(par);
    sendBit(~bad_stop);
    bus.ps2_data = 1'b1;
    repeat (40) @(negedge clk);
  endtask

  task automatic sendPartial(input logic [7:0] b, input int n_bits);
    sendBit(1'b0);
    for (int i = 0; i < n_bits - 1; i++) sendBit(b[i]);
    bus.ps2_data = 1'b1;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_raw_code"},  32'(bus.raw_code),  32'd0);
    checkOutput({tag, "_raw_valid"}, 32'(bus.raw_valid), 32'd0);
    checkOutput({tag, "_key_code"},  32'(bus.key_code),  32'd0);
    checkOutput({tag, "_key_ext"},   32'(bus.key_ext),   32'd0);
    checkOutput({tag, "_key_break"}, 32'(bus.key_break), 32'd0);
    checkOutput({tag, "_key_valid"}, 32'(bus.key_valid), 32'd0);
    checkOutput({tag, "_err"},       32'(bus.err),       32'd0);
    checkOutput({tag, "_err_code"},  32'(bus.err_code),  32'd0);
    checkOutput({tag, "_busy"},      32'(bus.busy),      32'd0);
  endtask

  initial begin
    #900_000;
    failCount++;
    $display("[TB] FAIL watchdog: observed timeout expected completion (cycle %0d)", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit seen;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    resetn = 1'b0;
    repeat (5) @(negedge clk);
    checkResetOutputs("reset");
    resetn = 1'b1;
    repeat (30) @(negedge clk);
    checkOutput("idle_busy", 32'(bus.busy), 32'd0);

    $display("[TB] plain make code, break prefix, extended break");
    applyStimulus(8'h1C, 0, 0);
    applyStimulus(8'hF0, 0, 0);
    applyStimulus(8'h1C, 0, 0);
    applyStimulus(8'hE0, 0, 0);
    applyStimulus(8'hF0, 0, 0);
    applyStimulus(8'h75, 0, 0);
    applyStimulus(8'h1C, 0, 0);

    $display("[TB] parity and framing errors");
    applyStimulus(8'h1C, 1, 0);
    checkOutput("raw_code_hold", 32'(bus.raw_code), 32'h1C);
    applyStimulus(8'h1C, 0, 1);
    checkOutput("key_code_hold", 32'(bus.key_code), 32'h1C);

    $display("[TB] timeout after partial frame");
    applyStimulus(8'hE0, 0, 0);
    sendPartial(8'h1C, 5);
    checkOutput("partial_busy", 32'(bus.busy), 32'd1);
    err_exp.code = ERR_TIMEOUT;
    err_exp.lo   = TO_CYCLES;
    err_exp.hi   = TO_CYCLES + LATENCY;
    err_q.push_back(err_exp);
    model_ext = 1'b0;
    model_brk = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < TO_CYCLES + 200 && !seen; i++) begin
      @(negedge clk);
      if (err_q.size() == 0) seen = 1'b1;
    end
    checkOutput("timeout_seen", 32'(seen), 32'd1);
    checkOutput("timeout_busy", 32'(bus.busy), 32'd0);
    repeat (20) @(negedge clk);
    checkOutput("err_code_hold", 32'(bus.err_code), 32'(ERR_TIMEOUT));
    applyStimulus(8'h1C, 0, 0);

    $display("[TB] short glitch on ps2_clk");
    bus.ps2_data = 1'b0;
    repeat (30) @(negedge clk);
    bus.ps2_clk = 1'b0;
    repeat (FILTER_LEN - 3) @(negedge clk);
    bus.ps2_clk = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("glitch_busy", 32'(bus.busy), 32'd0);
    bus.ps2_data = 1'b1;
    repeat (40) @(negedge clk);
    applyStimulus(8'h1C, 0, 0);

    $display("[TB] reset in the middle of a frame");
    applyStimulus(8'hE0, 0, 0);
    sendPartial(8'h75, 4);
    checkOutput("midframe_busy", 32'(bus.busy), 32'd1);
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checkResetOutputs("midreset");
    model_ext = 1'b0;
    model_brk = 1'b0;
    resetn = 1'b1;
    repeat (40) @(negedge clk);
    applyStimulus(8'h1C, 0, 0);

    repeat (20) @(negedge clk);
    checkOutput("raw_queue_drained", 32'(raw_q.size()), 32'd0);
    checkOutput("key_queue_drained", 32'(key_q.size()), 32'd0);
    checkOutput("err_queue_drained", 32'(err_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
    $finish;
  end

endmodule
